// File: rtl/uart_tx_rr_arbiter.sv
// Round-robin arbiter sharing one uart_TX transmitter between NUM_REQ byte producers.
// Launches one frame at a time, acks the winner on done, then holds off for GAP_CLKS.
module uart_tx_rr_arbiter #(
   parameter  int NUM_REQ  = 4,
   parameter  int GAP_CLKS = 2,
   localparam int IDX_W    = $clog2(NUM_REQ)
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst_n,
   input  logic [NUM_REQ-1:0]   i_Req,
   input  logic [NUM_REQ*8-1:0] i_Req_Bytes,
   output logic [NUM_REQ-1:0]   o_Ack,
   output logic                 o_Tx_DV,
   output logic [7:0]           o_Tx_Byte,
   input  logic                 i_Tx_Active,
   input  logic                 i_Tx_Done,
   output logic                 o_Busy,
   output logic [IDX_W-1:0]     o_Grant_Idx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_ACTIVE,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t                    state, state_next;
   logic [IDX_W-1:0]          r_Ptr;
   logic [7:0]                r_Gap_Cnt;
   logic                      r_Done_Prev;
   logic [NUM_REQ-1:0][7:0]   req_bytes;
   logic                      found;
   logic [IDX_W-1:0]          win_idx;
   int unsigned               cand;
   logic                      launch;
   logic                      finish;
   logic                      gap_done;
   logic [IDX_W-1:0]          ptr_next;

   assign req_bytes = i_Req_Bytes;

   // First pending request at or above r_Ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = 32'(r_Ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!found && i_Req[IDX_W'(cand)]) begin
            found   = 1'b1;
            win_idx = IDX_W'(cand);
         end
      end
   end

   assign ptr_next = (o_Grant_Idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_Grant_Idx + 1'b1;

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      o_Tx_DV    = 1'b0;
      launch     = 1'b0;
      finish     = 1'b0;
      gap_done   = 1'b0;
      case (state)
         S_IDLE: begin
            if (found && !i_Tx_Active) begin
               launch     = 1'b1;
               state_next = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            o_Tx_DV    = 1'b1;
            state_next = S_WAIT_ACTIVE;
         end
         S_WAIT_ACTIVE: begin
            if (i_Tx_Active) state_next = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // Only the first cycle of the two-cycle done pulse ends the frame.
            if (i_Tx_Done && !r_Done_Prev) begin
               finish     = 1'b1;
               state_next = S_GAP;
            end
         end
         S_GAP: begin
            if (r_Gap_Cnt == '0) begin
               gap_done   = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Ptr       <= '0;
         r_Gap_Cnt   <= '0;
         r_Done_Prev <= 1'b0;
         o_Ack       <= '0;
         o_Tx_Byte   <= '0;
         o_Busy      <= 1'b0;
         o_Grant_Idx <= '0;
      end else begin
         r_Done_Prev <= i_Tx_Done;
         o_Ack       <= '0;
         if (launch) begin
            o_Grant_Idx <= win_idx;
            o_Tx_Byte   <= req_bytes[win_idx];
            o_Busy      <= 1'b1;
         end
         if (finish) begin
            o_Ack     <= NUM_REQ'(1) << o_Grant_Idx;
            r_Ptr     <= ptr_next;
            r_Gap_Cnt <= 8'(GAP_CLKS - 1);
         end else if (state == S_GAP && r_Gap_Cnt != '0) begin
            r_Gap_Cnt <= r_Gap_Cnt - 1'b1;
         end
         if (gap_done) o_Busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// Directed bench for uart_tx_rr_arbiter driving a behavioural uart_TX model
// (start bit, 8 data bits LSB first, stop bit, two-cycle done pulse).
module tb_uart_tx_rr_arbiter;

   localparam int NUM_REQ      = 4;
   localparam int GAP_CLKS     = 2;
   localparam int CLKS_PER_BIT = 87;

   logic        clk = 1'b0;
   logic        i_Rst_n;
   logic [3:0]  i_Req;
   logic [31:0] i_Req_Bytes;
   logic [3:0]  o_Ack;
   logic        o_Tx_DV;
   logic [7:0]  o_Tx_Byte;
   logic        o_Busy;
   logic [1:0]  o_Grant_Idx;

   always #5 clk = ~clk;

   // Transmitter model
   typedef enum logic [2:0] {M_IDLE, M_START, M_DATA, M_STOP, M_CLEAN} mstate_t;
   mstate_t     m_state   = M_IDLE;
   int unsigned m_cnt     = 0;
   logic [2:0]  m_bit     = '0;
   logic [7:0]  m_byte    = '0;
   logic        tx_serial = 1'b1;
   logic        tx_active = 1'b0;
   logic        tx_done   = 1'b0;

   uart_tx_rr_arbiter #(.NUM_REQ(NUM_REQ), .GAP_CLKS(GAP_CLKS)) dut (
      .i_Clock     (clk),
      .i_Rst_n     (i_Rst_n),
      .i_Req       (i_Req),
      .i_Req_Bytes (i_Req_Bytes),
      .o_Ack       (o_Ack),
      .o_Tx_DV     (o_Tx_DV),
      .o_Tx_Byte   (o_Tx_Byte),
      .i_Tx_Active (tx_active),
      .i_Tx_Done   (tx_done),
      .o_Busy      (o_Busy),
      .o_Grant_Idx (o_Grant_Idx)
   );

   always @(posedge clk) begin
      case (m_state)
         M_IDLE: begin
            tx_serial <= 1'b1;
            tx_done   <= 1'b0;
            m_cnt     <= 0;
            m_bit     <= '0;
            if (o_Tx_DV) begin
               tx_active <= 1'b1;
               m_byte    <= o_Tx_Byte;
               m_state   <= M_START;
            end
         end
         M_START: begin
            tx_serial <= 1'b0;
            if (m_cnt < CLKS_PER_BIT - 1) m_cnt <= m_cnt + 1;
            else begin
               m_cnt   <= 0;
               m_state <= M_DATA;
            end
         end
         M_DATA: begin
            tx_serial <= m_byte[m_bit];
            if (m_cnt < CLKS_PER_BIT - 1) m_cnt <= m_cnt + 1;
            else begin
               m_cnt <= 0;
               if (m_bit < 3'd7) m_bit <= m_bit + 3'd1;
               else begin
                  m_bit   <= '0;
                  m_state <= M_STOP;
               end
            end
         end
         M_STOP: begin
            tx_serial <= 1'b1;
            if (m_cnt < CLKS_PER_BIT - 1) m_cnt <= m_cnt + 1;
            else begin
               m_cnt     <= 0;
               tx_done   <= 1'b1;
               tx_active <= 1'b0;
               m_state   <= M_CLEAN;
            end
         end
         default: begin
            tx_done <= 1'b1;
            m_state <= M_IDLE;
         end
      endcase
   end

   // Launch / ack monitor
   int unsigned cyc         = 0;
   int unsigned dv_count    = 0;
   int unsigned ack_count   = 0;
   int unsigned onehot_viol = 0;
   int unsigned dv_double   = 0;
   int unsigned min_gap     = 32'hFFFF_FFFF;
   int unsigned last_done   = 0;
   logic        have_done   = 1'b0;
   logic        done_q      = 1'b0;
   logic        dv_q        = 1'b0;
   logic [7:0]  q_byte[$];
   int unsigned q_grant[$];

   always @(negedge clk) begin
      cyc    <= cyc + 1;
      done_q <= tx_done;
      dv_q   <= o_Tx_DV;
      if (tx_done && !done_q) begin
         last_done <= cyc;
         have_done <= 1'b1;
      end
      if (o_Tx_DV) begin
         dv_count <= dv_count + 1;
         q_byte.push_back(o_Tx_Byte);
         q_grant.push_back(32'(o_Grant_Idx));
         if (have_done && (cyc - last_done) < min_gap) min_gap <= cyc - last_done;
         if (dv_q) dv_double <= dv_double + 1;
      end
      if (o_Ack != '0) ack_count <= ack_count + 1;
      if ($countones(o_Ack) > 1) onehot_viol <= onehot_viol + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(output logic [3:0] a);
      int unsigned n;
      n = 0;
      @(negedge clk);
      while (o_Ack == '0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      a = o_Ack;
   endtask

   task automatic wait_dv(output logic seen);
      int unsigned n;
      n = 0;
      @(negedge clk);
      while (!o_Tx_DV && n < 4000) begin
         @(negedge clk);
         n++;
      end
      seen = o_Tx_DV;
   endtask

   initial begin
      logic [3:0]  a;
      logic        seen;
      logic [9:0]  exp_frame;
      int unsigned saved;
      int unsigned early;
      int unsigned n;

      i_Rst_n     = 1'b0;
      i_Req       = '0;
      i_Req_Bytes = '0;
      repeat (2) @(negedge clk);
      check("rst_ack",   32'(o_Ack), 32'h0);
      check("rst_dv",    32'(o_Tx_DV), 32'h0);
      check("rst_byte",  32'(o_Tx_Byte), 32'h0);
      check("rst_busy",  32'(o_Busy), 32'h0);
      check("rst_grant", 32'(o_Grant_Idx), 32'h0);
      i_Rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Single request, serial frame of 8'hA5
      i_Req_Bytes[7:0] = 8'hA5;
      i_Req            = 4'b0001;
      @(negedge clk);
      check("t1_dv",    32'(o_Tx_DV), 32'h1);
      check("t1_busy",  32'(o_Busy), 32'h1);
      check("t1_byte",  32'(o_Tx_Byte), 32'hA5);
      check("t1_grant", 32'(o_Grant_Idx), 32'h0);
      @(negedge clk);
      check("t1_dv_one_cycle", 32'(o_Tx_DV), 32'h0);
      repeat (44) @(negedge clk);
      exp_frame = {1'b1, 8'hA5, 1'b0};
      for (int k = 0; k < 10; k++) begin
         check($sformatf("t1_serial_bit%0d", k), 32'(tx_serial), 32'(exp_frame[k]));
         if (k < 9) repeat (CLKS_PER_BIT) @(negedge clk);
      end
      wait_ack(a);
      check("t1_ack",      32'(a), 32'h1);
      check("t1_ack_busy", 32'(o_Busy), 32'h1);
      i_Req = '0;
      @(negedge clk);
      check("t1_ack_pulse", 32'(o_Ack), 32'h0);
      check("t1_gap_busy",  32'(o_Busy), 32'h1);
      @(negedge clk);
      check("t1_busy_fall", 32'(o_Busy), 32'h0);
      check("t1_ptr",       32'(dut.r_Ptr), 32'h1);

      i_Rst_n = 1'b0;
      @(negedge clk);
      check("idle_rst_ptr", 32'(dut.r_Ptr), 32'h0);
      i_Rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // All four requesters at once
      i_Req_Bytes = 32'h4433_2211;
      i_Req       = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         wait_ack(a);
         check($sformatf("t2_ack%0d", i), 32'(a), 32'(1) << i);
         i_Req = i_Req & ~a;
      end
      repeat (10) @(negedge clk);
      check("t2_launches", 32'(q_byte.size()), 32'd5);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_byte%0d", i),  32'(q_byte[i+1]), 32'(8'h11 * (i + 1)));
         check($sformatf("t2_grant%0d", i), q_grant[i+1], 32'(i));
      end
      check("t2_min_gap_ok", 32'(min_gap >= GAP_CLKS), 32'h1);

      // Fairness between requesters 0 and 2
      i_Req_Bytes = 32'h00B2_00B0;
      i_Req       = 4'b0101;
      for (int i = 0; i < 6; i++) begin
         wait_ack(a);
         check($sformatf("t3_ack%0d", i),   32'(a), (i % 2 == 0) ? 32'h1 : 32'h4);
         check($sformatf("t3_grant%0d", i), 32'(o_Grant_Idx), (i % 2 == 0) ? 32'h0 : 32'h2);
      end
      i_Req = '0;
      check("t3_ptr", 32'(dut.r_Ptr), 32'h3);

      // Wrap-around from pointer 3
      i_Req_Bytes = 32'h0000_C1C0;
      i_Req       = 4'b0011;
      wait_ack(a);
      check("t4_ack_first", 32'(a), 32'h1);
      i_Req[0] = 1'b0;
      wait_ack(a);
      check("t4_ack_second", 32'(a), 32'h2);
      i_Req = '0;

      // Reset in the middle of data bit 3
      i_Req_Bytes[23:16] = 8'hC3;
      i_Req              = 4'b0100;
      wait_dv(seen);
      check("t6_dv_seen", 32'(seen), 32'h1);
      check("t6_grant",   32'(o_Grant_Idx), 32'h2);
      @(posedge clk);
      repeat (4 * CLKS_PER_BIT + 44) @(negedge clk);
      i_Rst_n = 1'b0;
      #1;
      check("t6_rst_ack",   32'(o_Ack), 32'h0);
      check("t6_rst_dv",    32'(o_Tx_DV), 32'h0);
      check("t6_rst_byte",  32'(o_Tx_Byte), 32'h0);
      check("t6_rst_busy",  32'(o_Busy), 32'h0);
      check("t6_rst_grant", 32'(o_Grant_Idx), 32'h0);
      saved              = ack_count;
      i_Req_Bytes[15:8]  = 8'h96;
      i_Req              = 4'b0110;
      repeat (3) @(negedge clk);
      i_Rst_n = 1'b1;
      early   = 0;
      n       = 0;
      while (tx_active === 1'b1 && n < 2000) begin
         if (o_Tx_DV) early++;
         @(negedge clk);
         n++;
      end
      check("t6_tx_idle",  32'(tx_active), 32'h0);
      check("t6_no_early", early, 32'd0);
      wait_dv(seen);
      check("t6_relaunch",    32'(seen), 32'h1);
      check("t6_regrant",     32'(o_Grant_Idx), 32'h1);
      check("t6_rebyte",      32'(o_Tx_Byte), 32'h96);
      check("t6_no_lost_ack", ack_count, saved);
      wait_ack(a);
      check("t6_ack1", 32'(a), 32'h2);
      i_Req = 4'b0100;
      wait_ack(a);
      check("t6_ack2", 32'(a), 32'h4);
      i_Req = '0;

      // Request dropped during data bit 4
      i_Req_Bytes[31:24] = 8'h5A;
      i_Req              = 4'b1000;
      wait_dv(seen);
      check("t5_dv_seen", 32'(seen), 32'h1);
      check("t5_grant",   32'(o_Grant_Idx), 32'h3);
      @(posedge clk);
      repeat (5 * CLKS_PER_BIT + 44) @(negedge clk);
      i_Req = '0;
      check("t5_byte_held", 32'(o_Tx_Byte), 32'h5A);
      check("t5_busy",      32'(o_Busy), 32'h1);
      saved = dv_count;
      wait_ack(a);
      check("t5_ack", 32'(a), 32'h8);
      repeat (300) @(negedge clk);
      check("t5_no_relaunch", dv_count, saved);

      check("ack_onehot", onehot_viol, 32'd0);
      check("dv_single",  dv_double, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
